// File: rtl/sine_table_loader.sv
// Streams words into two 32x128 SRAM banks via port 0, one registered write per accepted word (1-cycle latency), done pulses 1 cycle after the last word.
// s_ready is high only in LOAD without abort; SINE_TABLE_LOADER_CHECKSUM_EN adds a running sum of accepted words on chksum.
module sine_table_loader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int WMASK_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W:0]    load_len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  output logic               csb00,
  output logic               csb10,
  output logic               web0,
  output logic [WMASK_W-1:0] wmask0,
  output logic [ADDR_W-2:0]  addr0,
  output logic [DATA_W-1:0]  din0,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               tbl_valid
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]  chksum
`endif
);

  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_csb00;
  logic              r_csb10;
  logic              r_web0;
  logic [ADDR_W-2:0] r_addr0;
  logic [DATA_W-1:0] r_din0;
  logic              r_err;
  logic              r_tbl_valid;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic              w_hs;
  logic              w_last_word;

  assign s_ready     = (r_state == ST_LOAD) && !abort;
  assign w_hs        = s_valid && s_ready;
  assign w_last_word = (r_remaining == LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (abort)                              w_state_nxt = ST_IDLE;
        else if (w_hs && (w_last_word || s_last)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Port-0 controls default to idle every cycle; only an accepted word pulls them low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csb00     <= 1'b1;
      r_csb10     <= 1'b1;
      r_web0      <= 1'b1;
      r_addr0     <= '0;
      r_din0      <= '0;
      r_err       <= 1'b0;
      r_tbl_valid <= 1'b0;
      r_ptr       <= '0;
      r_remaining <= '0;
    end else begin
      r_csb00 <= 1'b1;
      r_csb10 <= 1'b1;
      r_web0  <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ptr       <= start_addr;
            r_remaining <= (load_len == '0) ? LEN_W'(2 ** ADDR_W) : load_len;
            r_err       <= 1'b0;
            r_tbl_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_hs) begin
            r_csb00     <= r_ptr[ADDR_W-1];
            r_csb10     <= ~r_ptr[ADDR_W-1];
            r_web0      <= 1'b0;
            r_addr0     <= r_ptr[ADDR_W-2:0];
            r_din0      <= s_data;
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
            // s_last must coincide exactly with the final counted word.
            if (w_last_word != s_last) r_err <= 1'b1;
          end
        end
        ST_DONE: r_tbl_valid <= !r_err;
        default: ;
      endcase
    end
  end

`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_chksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_chksum <= '0;
    else if (r_state == ST_IDLE && start)  r_chksum <= '0;
    else if (w_hs)                         r_chksum <= r_chksum + s_data;
  end

  assign chksum = r_chksum;
`endif

  assign csb00     = r_csb00;
  assign csb10     = r_csb10;
  assign web0      = r_web0;
  assign wmask0    = {WMASK_W{1'b1}};
  assign addr0     = r_addr0;
  assign din0      = r_din0;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign tbl_valid = r_tbl_valid;

endmodule
